// File: rtl/uart_rx.sv
// uart_rx: UART receive deserializer feeding the debug/loader controller.
//   Recovers 8N1 frames from the raw rx pin and holds each byte in a
//   single-entry register behind a valid/ready handshake. Runs on the
//   free-running board clock.
//   Optional feature macro: UART_RX_PARITY_EN (8E1 framing with parity check).
// Ports:
//   clk        in   board clock, rising edge
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous serial input, idle high
//   data[7:0]  out  received byte, stable while valid=1
//   valid      out  byte available in the holding register
//   ready      in   consumer takes the byte when valid&&ready
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   overrun    out  one-cycle pulse, completed byte dropped (register full)
//   parity_err out  one-cycle pulse, parity mismatch (0 without UART_RX_PARITY_EN)
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY     = 3'd5;
    localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
    localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [2:0]             state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [2:0]             bit_idx, bit_idx_d;
    logic [7:0]             shift, shift_d;
    logic                   stop_ok_c;
    logic                   stop_bad_c;
    logic                   deliver_c;
`ifdef UART_RX_PARITY_EN
    logic                   par_bit, par_bit_d;
    logic                   par_bad_c;
`endif

    // Input synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // FSM and datapath state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bit <= par_bit_d;
`endif
        end
    end

    // Next-state logic; all bit samples land on the middle of the bit period
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        bit_idx_d  = bit_idx;
        shift_d    = shift;
        stop_ok_c  = 1'b0;
        stop_bad_c = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d  = par_bit;
`endif
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt == CNT_MID) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        bit_idx_d = '0;
                        state_d   = ST_DATA;
                    end else begin
                        // start bit did not survive to mid-bit: a glitch
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt == CNT_END) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_d = ST_AFTER_DATA;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt == CNT_END) begin
                    cnt_d     = '0;
                    par_bit_d = rx_s;
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (cnt == CNT_END) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        stop_ok_c = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        stop_bad_c = 1'b1;
                        state_d    = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                // wait out a line break / long low before hunting again
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    // even parity: XOR over data and parity bit must be 0
    assign par_bad_c = ^{shift, par_bit};
    assign deliver_c = stop_ok_c && !par_bad_c;
`else
    assign deliver_c = stop_ok_c;
`endif

    // Holding register, handshake and error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad_c;
            overrun   <= deliver_c && valid && !ready;
            if (deliver_c && (!valid || ready)) begin
                // empty register, or old byte consumed this same cycle
                data  <= shift;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity pulse is suppressed when the stop bit is bad
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= stop_ok_c && par_bad_c;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (CLKS_PER_BIT=16, SYNC_STAGES=2).
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned CPB  = 16;
    localparam int unsigned SYNC = 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    // rx falling edge to valid rising, in clk cycles
    localparam int LAT = int'(SYNC + CPB / 2 + (PAR ? 10 : 9) * CPB + 1);

    localparam int K_GOOD = 0;
    localparam int K_FERR = 1;
    localparam int K_PERR = 2;

    typedef struct {
        int         kind;
        logic [7:0] b;
        int         due;
    } ev_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       rx    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    ev_t        q[$];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    int         n_load = 0, n_fe = 0, n_ov = 0, n_pe = 0, n_vcyc = 0;
    int         b_ld = 0, b_fe = 0, b_ov = 0, b_pe = 0, b_vc = 0;
    logic [7:0] last_ld = 8'h00;
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       pv      = 1'b0;
    bit         rand_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: holding register plus a queue of expected frame outcomes
    always @(posedge clk) begin : monitor
        logic       ld;
        logic       mloaded;
        logic [3:0] obs_v;
        logic [3:0] exp_v;
        ev_t        e;
        #1;
        cyc++;
        if (rst) begin
            q.delete();
            m_valid = 1'b0;
            m_data  = 8'h00;
            chk("reset_outputs", {20'd0, data, valid, frame_err, overrun, parity_err}, 32'd0);
        end else begin
            mloaded = 1'b0;
            ld      = valid && (!pv || ready);
            obs_v   = {ld, frame_err, overrun, parity_err};
            if (ld) begin
                n_load++;
                last_ld = data;
            end
            if (frame_err)  n_fe++;
            if (overrun)    n_ov++;
            if (parity_err) n_pe++;
            if (valid)      n_vcyc++;
            if (obs_v != 4'b0000) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", {28'd0, obs_v}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("event_time", (cyc >= e.due - 1 && cyc <= e.due + 1) ? e.due : cyc, e.due);
                    if (e.kind == K_GOOD) begin
                        if (!m_valid || ready) begin
                            exp_v = 4'b1000;
                            chk("load_data", {24'd0, data}, {24'd0, e.b});
                            m_valid = 1'b1;
                            m_data  = e.b;
                            mloaded = 1'b1;
                        end else begin
                            exp_v = 4'b0010;
                        end
                    end else if (e.kind == K_FERR) begin
                        exp_v = 4'b0100;
                    end else begin
                        exp_v = 4'b0001;
                    end
                    chk("event_kind", {28'd0, obs_v}, {28'd0, exp_v});
                end
            end else if (q.size() != 0 && cyc > q[0].due + 1) begin
                chk("event_timeout", cyc, q[0].due);
                e = q.pop_front();
            end
            if (!mloaded && m_valid && ready) m_valid = 1'b0;
            chk("valid", {31'd0, valid}, {31'd0, m_valid});
            chk("data", {24'd0, data}, {24'd0, m_data});
        end
        pv = valid;
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rand_ready) ready = 1'($urandom_range(0, 1));
        end
    endtask

    // Drives one frame and records its expected outcome; leaves the stop level on rx
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        ev_t e;
        e.b   = b;
        e.due = cyc + LAT;
        if (!stop_ok)            e.kind = K_FERR;
        else if (PAR && !par_ok) e.kind = K_PERR;
        else                     e.kind = K_GOOD;
        q.push_back(e);
        rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(CPB);
        end
        if (PAR) begin
            rx = (^b) ^ !par_ok;
            wait_cycles(CPB);
        end
        rx = stop_ok;
        wait_cycles(CPB);
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            wait_cycles(1);
            n++;
        end
        if (q.size() != 0) chk("settle_queue_empty", q.size(), 0);
        wait_cycles(4);
    endtask

    task automatic snap();
        b_ld = n_load; b_fe = n_fe; b_ov = n_ov; b_pe = n_pe; b_vc = n_vcyc;
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog actual=timeout expected=finish cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        repeat (5) @(negedge clk);
        rst = 1'b0;
        wait_cycles(10);

        // single byte, ready held high
        ready = 1'b1;
        snap();
        send_frame(8'hA5, 1'b1, 1'b1);
        settle();
        chk("a5_last", {24'd0, last_ld}, 32'h0000_00A5);
        chk("a5_loads", n_load - b_ld, 1);
        chk("a5_valid_cycles", n_vcyc - b_vc, 1);
        chk("a5_errors", (n_fe - b_fe) + (n_ov - b_ov) + (n_pe - b_pe), 0);

        // back-to-back with consumer stalled: second byte overruns
        ready = 1'b0;
        snap();
        send_frame(8'h3C, 1'b1, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b1);
        settle();
        chk("ovr_data", {24'd0, data}, 32'h0000_003C);
        chk("ovr_valid", {31'd0, valid}, 32'd1);
        chk("ovr_pulses", n_ov - b_ov, 1);
        chk("ovr_loads", n_load - b_ld, 1);
        @(negedge clk);
        ready = 1'b1;
        @(posedge clk);
        #2;
        chk("ovr_valid_clear", {31'd0, valid}, 32'd0);
        @(negedge clk);

        // 5-cycle glitch on idle line, then a clean frame
        snap();
        rx = 1'b0;
        wait_cycles(5);
        rx = 1'b1;
        wait_cycles(3 * CPB);
        chk("glitch_valid", {31'd0, valid}, 32'd0);
        chk("glitch_events", (n_load - b_ld) + (n_fe - b_fe) + (n_ov - b_ov) + (n_pe - b_pe), 0);
        send_frame(8'h55, 1'b1, 1'b1);
        settle();
        chk("glitch_next_byte", {24'd0, last_ld}, 32'h0000_0055);

        // bad stop bit followed by a long break
        snap();
        send_frame(8'h81, 1'b0, 1'b1);
        wait_cycles(40 * CPB);
        rx = 1'b1;
        wait_cycles(2 * CPB);
        chk("break_fe", n_fe - b_fe, 1);
        chk("break_loads", n_load - b_ld, 0);
        send_frame(8'h7E, 1'b1, 1'b1);
        settle();
        chk("break_next_byte", {24'd0, last_ld}, 32'h0000_007E);
        chk("break_fe_total", n_fe - b_fe, 1);

        // reset mid-frame with a byte still held
        ready = 1'b0;
        send_frame(8'h99, 1'b1, 1'b1);
        settle();
        rx = 1'b0;
        wait_cycles(CPB);
        rx = 1'b1;
        wait_cycles(4 * CPB + CPB / 2);
        rst = 1'b1;
        wait_cycles(4);
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        rst = 1'b0;
        wait_cycles(2 * CPB);
        chk("post_rst_valid", {31'd0, valid}, 32'd0);
        ready = 1'b1;
        send_frame(8'h12, 1'b1, 1'b1);
        settle();
        chk("post_rst_byte", {24'd0, last_ld}, 32'h0000_0012);
        chk("post_rst_data", {24'd0, data}, 32'h0000_0012);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight, so even parity bit is 1
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0);
        settle();
        chk("par_loads", n_load - b_ld, 1);
        chk("par_pulses", n_pe - b_pe, 1);
        chk("par_byte", {24'd0, last_ld}, 32'h0000_0007);
`endif

        // randomized frames, stop/parity faults and consumer back-pressure
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            logic [7:0] b;
            bit         s_ok;
            bit         p_ok;
            b    = 8'($urandom);
            s_ok = ($urandom_range(0, 5) != 0);
            p_ok = ($urandom_range(0, 4) != 0);
            send_frame(b, s_ok, p_ok);
            if (!s_ok) begin
                rx = 1'b1;
                wait_cycles(2 * CPB);
            end else if ($urandom_range(0, 2) != 0) begin
                wait_cycles(int'($urandom_range(1, 40)));
            end
        end
        rand_ready = 1'b0;
        ready = 1'b1;
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
